chroni_font_serializer: RTL
===========================

Name: chroni_font_serializer

Overview:
- Text-mode pixel stage between the 2K font ROM and the chroni VGA output.
- Accepts character-cell requests (char code, glyph row, fg/bg colour indices), issues the 11-bit font ROM address and captures the glyph byte.
- Serializes the byte MSB-first, one pixel per pixel_en, as RGB565 through a fixed 16-entry palette.
- Small prefetch buffer lets fetches run ahead of the raster.

Parameters:
- ROM_LATENCY, 1: cycles from rom_addr registered to rom_data valid; legal values are 1 and 2.
- BUF_DEPTH, 2: glyph buffer entries; power of two, 2..4.

Ports:
- vga_clk  in  1  pixel-domain clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cell request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_char  in  8  character code.
- req_row  in  3  glyph row, 0..7.
- req_fg  in  4  foreground palette index.
- req_bg  in  4  background palette index.
- rom_addr  out  11  font ROM address, {char, row}, registered.
- rom_data  in  8  font ROM byte.
- pixel_en  in  1  advance one pixel.
- line_start  in  1  synchronous flush at start of each active line.
- border_idx  in  4  palette index output on underrun.
- pix_r  out  5  pixel red.
- pix_g  out  6  pixel green.
- pix_b  out  5  pixel blue.
- pix_valid  out  1  pix_* updated this cycle.
- underrun  out  1  sticky: pixel requested with no glyph data.

Behaviour:
- Reset (async, reset_n=0): rom_addr=0, pix_r/g/b=0, pix_valid=0, underrun=0, buffer empty, shifter empty, tag pipe cleared.
- req_ready=1 iff (buffer occupancy + in-flight fetches) < BUF_DEPTH and line_start=0. req_ready is combinational from registered state and line_start only, never from req_valid.
- Accept on req_valid & req_ready at edge N:
  - rom_addr <= {req_char, req_row} at edge N.
  - A tag {fg, bg} enters a delay pipe of ROM_LATENCY+1 stages.
  - At edge N+1+ROM_LATENCY, {rom_data, fg, bg} is written into the buffer.
  - rom_addr holds its last value when there is no accept.
- Shifter holds byte, fg, bg and a 3-bit remaining counter (0 = empty).
- On pixel_en:
  - Shifter non-empty: emit the current MSB, shift left, decrement the counter.
  - Shifter empty and buffer non-empty: pop the buffer, emit bit7, leave 7 bits remaining.
  - Both empty: emit palette[border_idx] and set underrun=1.
  - Emitted colour is palette[fg] when the bit is 1, palette[bg] when it is 0.
- Output timing: pix_r/g/b and pix_valid are registered, one cycle after pixel_en. pix_valid=0 otherwise; pix_r/g/b hold.
- A buffer write and a pop in the same cycle are both legal. Occupancy is unchanged and data ordering is preserved.
- Buffer full with an in-flight return is impossible by the req_ready rule.
- line_start=1 (highest priority over accept, pixel_en and writes that cycle):
  - Clears the buffer, shifter and tag pipe; ROM data still in flight is discarded.
  - Clears underrun.
  - pix_valid=0 next cycle.
  - rom_addr unchanged.
- Occupancy counter width is clog2(BUF_DEPTH)+1. Buffer pointers wrap modulo BUF_DEPTH.

Optional Feature:
- CHRONI_DOUBLE_WIDTH_EN defined:
  - Adds input port double_width (1 bit).
  - When double_width=1, each glyph bit is emitted on two consecutive pixel_en; the counter tracks half-steps (16 pixels per cell).
  - double_width is sampled only when a byte is loaded into the shifter.
  - Underrun pixels are single width.
- Undefined: no double_width port; one pixel per bit, always.

Decomposition:
- Package chroni_pkg holds:
  - CHRONI_PALETTE, a 16x16-bit RGB565 constant array.
  - FONT_ADDR_W=11.
  - Glyph-entry struct typedef {byte[7:0], fg[3:0], bg[3:0]}.
- One sub-module, chroni_glyph_fifo: parameterised BUF_DEPTH FIFO with push/pop/flush/count.
- Tag pipe and shifter live in the top module.

Test Plan:
- Reset release, one request (char=0x41, row=3, fg=15, bg=0):
  - rom_addr=0x20B the cycle after accept.
  - ROM model returns 0xA5.
  - 8 pixel_en pulses give pix_valid with palette 15,0,15,0,0,15,0,15; underrun stays 0.
- Flow control:
  - Hold req_valid with no pixel_en: exactly BUF_DEPTH accepts (2), then req_ready=0.
  - One glyph consumed (8 pixel_en): req_ready returns to 1 after the pop.
- Underrun:
  - pixel_en with nothing buffered: pix = palette[border_idx=4], underrun=1.
  - underrun stays 1 until line_start, then reads 0.
- line_start during an in-flight fetch (accept, then line_start at N+1):
  - Returned ROM byte is not buffered.
  - Next pixel_en underruns.
  - req_ready=0 during line_start, 1 after.
- ROM_LATENCY=2 build: back-to-back requests chars 0x00 and 0x01 with pixel_en every cycle produce 16 continuous pixels with no underrun after pipeline fill.
- CHRONI_DOUBLE_WIDTH_EN build, double_width=1, byte 0x80:
  - Two fg pixels, then 14 bg pixels.
  - Next byte loads on the 17th pixel_en.

Source files
------------

// File: rtl/chroni_pkg.sv
// chroni shared types: RGB565 palette, font address width, glyph entry.
// Imported by chroni_glyph_fifo and chroni_font_serializer.
package chroni_pkg;

  localparam int FONT_ADDR_W = 11;

  localparam logic [15:0] CHRONI_PALETTE [16] = '{
    16'h0000, 16'h0015, 16'h0540, 16'h0555,
    16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
    16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
    16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
  };

  typedef struct packed {
    logic [7:0] glyph;
    logic [3:0] fg;
    logic [3:0] bg;
  } glyph_t;

endpackage

// File: rtl/chroni_glyph_fifo.sv
// Glyph prefetch FIFO: push/pop/flush, occupancy count, comb read port.
// Ports: vga_clk, reset_n, push, din, pop, flush, dout, count, empty.
module chroni_glyph_fifo
  import chroni_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          push,
  input  glyph_t        din,
  input  logic          pop,
  input  logic          flush,
  output glyph_t        dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  glyph_t        mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge vga_clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/chroni_font_serializer.sv
// Text-mode pixel stage: font ROM fetch, glyph prefetch, MSB-first RGB565 out.
// Ports: req_* in, rom_addr/rom_data, pixel_en, line_start, border_idx,
// pix_r/g/b, pix_valid, underrun. CHRONI_DOUBLE_WIDTH_EN adds double_width.
module chroni_font_serializer
  import chroni_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_char,
  input  logic [2:0]             req_row,
  input  logic [3:0]             req_fg,
  input  logic [3:0]             req_bg,
  output logic [FONT_ADDR_W-1:0] rom_addr,
  input  logic [7:0]             rom_data,
  input  logic                   pixel_en,
  input  logic                   line_start,
  input  logic [3:0]             border_idx,
  output logic [4:0]             pix_r,
  output logic [5:0]             pix_g,
  output logic [4:0]             pix_b,
  output logic                   pix_valid,
  output logic                   underrun
`ifdef CHRONI_DOUBLE_WIDTH_EN
  ,
  input  logic                   double_width
`endif
);

  localparam int NT = ROM_LATENCY + 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;

`ifdef CHRONI_DOUBLE_WIDTH_EN
  // Half-step counter: 15 remaining after the first pixel of a wide cell.
  localparam int SCW = 4;
  logic ld_dbl;
  assign ld_dbl = double_width;
`else
  localparam int SCW = 3;
  logic ld_dbl;
  assign ld_dbl = 1'b0;
`endif

  logic [NT-1:0]      tp_vld;
  logic [NT-1:0][7:0] tp_tag;
  logic [3:0]         inflight;
  logic [3:0]         pend_sum;
  logic               accept;

  glyph_t             fifo_din;
  glyph_t             fifo_dout;
  logic [CW-1:0]      occ;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [7:0]         sh_byte;
  logic [3:0]         sh_fg;
  logic [3:0]         sh_bg;
  logic [SCW-1:0]     sh_cnt;
  logic               sh_dbl;
  logic               sh_empty;
  logic               use_border;
  logic               bit_v;
  logic [3:0]         fg_i;
  logic [3:0]         bg_i;
  logic [3:0]         pix_idx;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NT; i++) begin
      inflight = inflight + {3'b000, tp_vld[i]};
    end
  end

  // Slots already promised to in-flight fetches count as occupied,
  // so a returning byte always finds room.
  assign pend_sum  = 4'(occ) + inflight;
  assign req_ready = (pend_sum < 4'(BUF_DEPTH)) && !line_start;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
    end else if (accept) begin
      rom_addr <= {req_char, req_row};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tp_vld <= '0;
      tp_tag <= '0;
    end else if (line_start) begin
      tp_vld <= '0;
    end else begin
      tp_vld[0] <= accept;
      tp_tag[0] <= {req_fg, req_bg};
      for (int i = 1; i < NT; i++) begin
        tp_vld[i] <= tp_vld[i-1];
        tp_tag[i] <= tp_tag[i-1];
      end
    end
  end

  assign push           = tp_vld[NT-1] && !line_start;
  assign fifo_din.glyph = rom_data;
  assign fifo_din.fg    = tp_tag[NT-1][7:4];
  assign fifo_din.bg    = tp_tag[NT-1][3:0];

  chroni_glyph_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .flush   (line_start),
    .dout    (fifo_dout),
    .count   (occ),
    .empty   (fifo_empty)
  );

  always_comb begin
    sh_empty   = (sh_cnt == '0);
    use_border = sh_empty && fifo_empty;
    pop        = pixel_en && !line_start && sh_empty && !fifo_empty;
    if (!sh_empty) begin
      bit_v = sh_byte[7];
      fg_i  = sh_fg;
      bg_i  = sh_bg;
    end else begin
      bit_v = fifo_dout.glyph[7];
      fg_i  = fifo_dout.fg;
      bg_i  = fifo_dout.bg;
    end
    pix_idx = use_border ? border_idx : (bit_v ? fg_i : bg_i);
  end

  // A wide cell shifts only on the second half of each bit (odd count).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_byte <= '0;
      sh_fg   <= '0;
      sh_bg   <= '0;
      sh_cnt  <= '0;
      sh_dbl  <= 1'b0;
    end else if (line_start) begin
      sh_cnt  <= '0;
    end else if (pixel_en) begin
      if (!sh_empty) begin
        sh_cnt <= sh_cnt - SCW'(1);
        if (!sh_dbl || sh_cnt[0]) begin
          sh_byte <= {sh_byte[6:0], 1'b0};
        end
      end else if (!fifo_empty) begin
        sh_fg   <= fifo_dout.fg;
        sh_bg   <= fifo_dout.bg;
        sh_dbl  <= ld_dbl;
        sh_cnt  <= ld_dbl ? SCW'(15) : SCW'(7);
        sh_byte <= ld_dbl ? fifo_dout.glyph
                          : {fifo_dout.glyph[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (line_start) begin
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (pixel_en) begin
      pix_valid <= 1'b1;
      {pix_r, pix_g, pix_b} <= CHRONI_PALETTE[pix_idx];
      if (use_border) underrun <= 1'b1;
    end else begin
      pix_valid <= 1'b0;
    end
  end

endmodule
